// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer: controller state codes, BCD limits
// and the internal countdown phase encoding.
package egg_timer_pkg;

    typedef enum logic [3:0] {
        ST_SET_SEC     = 4'd0,
        ST_SET_MIN     = 4'd1,
        ST_TIMER       = 4'd2,
        ST_READY       = 4'd3,
        ST_RESET       = 4'd4,
        ST_FLASH_ON    = 4'd5,
        ST_FLASH_OFF   = 4'd6,
        ST_SETTING_MIN = 4'd7
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_COUNT,
        PH_EXPIRED,
        PH_ALARM
    } phase_e;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // True when both digits are legal for a counter whose tens digit tops out at tens_max.
    function automatic logic bcd2_valid(input logic [7:0] value, input logic [3:0] tens_max);
        return (value[7:4] <= tens_max) && (value[3:0] <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd2_down.sv
// Two-digit BCD down-counter with synchronous load; wraps 00 to TENS_MAX9
// and flags the wrap as a borrow for the next-higher counter.
module bcd2_down
    import egg_timer_pkg::*;
#(
    parameter logic [3:0] TENS_MAX = SEC_TENS_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] value,
    output logic       borrow,
    output logic       zero
);

    logic [3:0] tens;
    logic [3:0] ones;

    // Load wins over decrement so a controller entry is never lost to a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (load) begin
            tens <= load_val[7:4];
            ones <= load_val[3:0];
        end else if (dec) begin
            if (ones == 4'd0) begin
                ones <= DIGIT_MAX;
                tens <= (tens == 4'd0) ? TENS_MAX : tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

    assign value  = {tens, ones};
    assign zero   = (value == 8'h00);
    assign borrow = dec && zero;

endmodule

// File: rtl/countdown_sequencer.sv
// Egg timer countdown datapath: switch capture, 1 Hz prescaler, MM:SS BCD
// countdown, expiry flag and alarm-phase blink generation.
module countdown_sequencer
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int FLASH_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic [7:0] sw,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       tick,
    output logic       running,
    output logic       done,
    output logic       blink
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int FW = $clog2(FLASH_DIV);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [FW-1:0] flash_cnt;
    phase_e        phase;

    logic       clear_all;
    logic       in_timer;
    logic       in_alarm;
    logic       in_set;
    logic       sec_zero;
    logic       min_zero;
    logic       sec_borrow;
    logic       min_borrow_unused;
    logic       value_zero;
    logic       step;
    logic       last_second;
    logic       expiring;
    logic       load_sec;
    logic       load_min;
    logic [7:0] load_val;

    // Undefined codes 8-15 behave exactly like the controller's RESET state.
    assign clear_all   = reset || state[3] || (state == ST_RESET);
    assign in_timer    = (state == ST_TIMER);
    assign in_alarm    = (state == ST_FLASH_ON) || (state == ST_FLASH_OFF);
    assign in_set      = (state == ST_SET_SEC) || (state == ST_SET_MIN);
    assign value_zero  = sec_zero && min_zero;
    assign step        = in_timer && !reset && !value_zero && (prescaler == PRE_LAST);
    assign last_second = min_zero && (sec_bcd == 8'h01);
    assign expiring    = in_timer && (value_zero || (step && last_second));

    assign load_sec = clear_all || ((state == ST_SET_SEC) && bcd2_valid(sw, SEC_TENS_MAX));
    assign load_min = clear_all || ((state == ST_SET_MIN) && bcd2_valid(sw, DIGIT_MAX));
    assign load_val = clear_all ? 8'h00 : sw;

    bcd2_down #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .load     (load_sec),
        .load_val (load_val),
        .dec      (step),
        .value    (sec_bcd),
        .borrow   (sec_borrow),
        .zero     (sec_zero)
    );

    // Minutes never borrow: stepping is suppressed once the whole value reaches 00:00.
    bcd2_down #(.TENS_MAX(DIGIT_MAX)) u_min (
        .clk      (clk),
        .reset    (reset),
        .load     (load_min),
        .load_val (load_val),
        .dec      (sec_borrow),
        .value    (min_bcd),
        .borrow   (min_borrow_unused),
        .zero     (min_zero)
    );

    always_ff @(posedge clk) begin
        if (clear_all) begin
            prescaler <= '0;
            flash_cnt <= '0;
            tick      <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            blink     <= 1'b1;
            phase     <= PH_IDLE;
        end else begin
            tick    <= step;
            running <= in_timer && !expiring;

            // Outside an active count the prescaler freezes so a paused run resumes mid-second.
            if (in_timer && !value_zero) begin
                prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
            end

            if (in_set) begin
                done <= 1'b0;
            end else if (expiring) begin
                done <= 1'b1;
            end

            if (in_alarm) begin
                if (phase != PH_ALARM) begin
                    blink     <= 1'b1;
                    flash_cnt <= '0;
                end else if (flash_cnt == FLASH_LAST) begin
                    blink     <= ~blink;
                    flash_cnt <= '0;
                end else begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end else begin
                blink     <= 1'b1;
                flash_cnt <= '0;
            end

            if (in_alarm) begin
                phase <= PH_ALARM;
            end else if (in_timer) begin
                phase <= expiring ? PH_EXPIRED : PH_COUNT;
            end else begin
                phase <= PH_IDLE;
            end
        end
    end

endmodule
